branch_history_table: RTL and testbench
=======================================

# branch_history_table

Dynamic direction predictor feeding the IF-stage branch prediction logic. Holds a table of 2-bit saturating counters indexed by fetch PC and returns a taken/not-taken prediction for each branch in IF. It carries that prediction with its table index into ID, then trains the indexed counter with the resolved outcome. It also maintains saturating branch and mispredict statistics counters for performance measurement.

## Interface
- ENTRIES, 16, number of counters; must be a power of two, 2..256
- IDX_W, 4, log2(ENTRIES)
- INIT_STATE, 2'b01, counter value after reset (weakly not-taken)
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- branch_IF  input  1  branch instruction present in IF
- PC_IF  input  32  PC of the instruction in IF
- branch_ID  input  1  branch instruction present in ID, outcome valid
- jump_or_not  input  1  resolved outcome in ID (1 = taken)
- stall  input  1  pipeline stall; freezes all state
- predict_jump  output  1  prediction for the IF branch (combinational)
- correct  output  1  ID prediction matched outcome (combinational)
- branch_cnt  output  16  resolved branches counted, saturating
- miss_cnt  output  16  mispredictions counted, saturating

## Operation
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; prediction = counter[1].
- Index = PC_IF[IDX_W+1:2]; word-aligned PCs, upper bits ignored (aliasing accepted).
- predict_jump = branch_IF ? table[idx_IF][1] : 0.
- Capture: at a posedge with branch_IF=1 and stall=0, latch idx_ID <= idx_IF and pred_ID <= predict_jump. Otherwise idx_ID and pred_ID hold.
- correct = 1 when branch_ID=0 or stall=1. Otherwise correct = (pred_ID == jump_or_not).
- Update: at a posedge with branch_ID=1 and stall=0:
  - taken: table[idx_ID] increments, saturating at 11
  - not taken: table[idx_ID] decrements, saturating at 00
- Stats update on the same condition:
  - branch_cnt increments
  - miss_cnt increments when correct=0
  - both saturate at 16'hFFFF; no wrap
- Simultaneous lookup and update of the same index in one cycle: lookup returns the pre-update value (no bypass). The write takes effect at the edge.
- Simultaneous capture and update at one edge: the update uses the old idx_ID; the capture writes the new one.
- branch_ID=1 with no prior capture since reset: the update uses idx_ID=0. This is legal and has no special handling.

## Timing
- Prediction: zero-latency combinational from PC_IF and branch_IF.
- Prediction to training: 1 cycle (captured at the IF edge, trained at the ID edge, one cycle later absent stalls).
- A new counter value is visible to lookups the cycle after the update edge.
- Reset (asynchronous, any time including mid-update):
  - all table entries = INIT_STATE
  - idx_ID = 0, pred_ID = 0
  - branch_cnt = 0, miss_cnt = 0
  - predict_jump = 0 and correct = 1 while branch_IF/branch_ID are 0
- Stall=1 blocks all register writes. Outputs are still evaluated combinationally; correct is forced to 1.

## Test plan
- Reset:
  - Stimulus: after reset, branch_IF=1 at PC_IF=0x40.
  - Required: predict_jump=0, branch_cnt=0, miss_cnt=0.
- Training:
  - Stimulus: branch at PC 0x40 resolves taken in ID twice (consecutive IF/ID pairs).
  - Required: 1st resolution correct=0, miss_cnt=1; counter 01->10; next lookup of 0x40 gives predict_jump=1. 2nd resolution correct=1; counter 10->11.
- Saturation and hysteresis:
  - Stimulus: three taken resolutions at 0x40 hold the counter at 11; then one not-taken.
  - Required: counter 10; predict_jump stays 1; correct=0 on that not-taken resolution.
- Aliasing and independence:
  - Stimulus: PC 0x44 trained taken, then lookups of PC 0x48 and PC 0x84.
  - Required: 0x48 (idx 2) still predicts 0; 0x84 (idx 1, aliases 0x44) predicts 1.
- Stall:
  - Stimulus: branch_ID=1, jump_or_not=1, stall=1 for 3 cycles.
  - Required: correct=1; table, idx_ID, branch_cnt and miss_cnt unchanged; update happens on the first cycle with stall=0.
- Stats saturation and async reset:
  - Stimulus: force 65536 resolutions, then pulse rst_n low mid-cycle (between edges).
  - Required: branch_cnt holds 0xFFFF; all state clears immediately without a clock edge.

Source files
------------

// File: rtl/branch_history_table_if.sv
// Signal bundle between the IF/ID branch logic and the branch history table.
// The master drives branch lookups and resolutions; the slave returns predictions and statistics.
interface branch_history_table_if;
  logic        branch_IF;
  logic [31:0] PC_IF;
  logic        branch_ID;
  logic        jump_or_not;
  logic        stall;
  logic        predict_jump;
  logic        correct;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  modport master (
    output branch_IF, PC_IF, branch_ID, jump_or_not, stall,
    input  predict_jump, correct, branch_cnt, miss_cnt
  );

  modport slave (
    input  branch_IF, PC_IF, branch_ID, jump_or_not, stall,
    output predict_jump, correct, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_history_table.sv
// 2-bit saturating-counter direction predictor: looks up in IF, carries the prediction
// and index into ID, trains the counter there, and keeps saturating branch/miss statistics.
module branch_history_table #(
  parameter int         ENTRIES    = 16,
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic                    clk,
  input logic                    rst_n,
  branch_history_table_if.slave  bus
);

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]       r_table [ENTRIES];
  logic [IDX_W-1:0] r_idx_p1;
  logic             r_pred_p1;
  logic [15:0]      r_branch_cnt;
  logic [15:0]      r_miss_cnt;

  logic [IDX_W-1:0] w_idx_p0;
  logic             w_pred_p0;
  logic             w_cap;
  logic             w_upd;
  logic             w_correct;
  logic [31-IDX_W:0] w_unused_pc;

  // IF stage: combinational lookup, no bypass from a same-cycle update
  assign w_idx_p0    = bus.PC_IF[IDX_W+1:2];
  assign w_unused_pc = {bus.PC_IF[31:IDX_W+2], bus.PC_IF[1:0]};
  assign w_pred_p0   = bus.branch_IF & r_table[w_idx_p0][1];
  assign w_cap       = bus.branch_IF & ~bus.stall;
  assign w_upd       = bus.branch_ID & ~bus.stall;
  assign w_correct   = ~w_upd | (r_pred_p1 == bus.jump_or_not);

  assign bus.predict_jump = w_pred_p0;
  assign bus.correct      = w_correct;
  assign bus.branch_cnt   = r_branch_cnt;
  assign bus.miss_cnt     = r_miss_cnt;

  // IF -> ID boundary: remember what was predicted and where
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx_p1  <= '0;
      r_pred_p1 <= 1'b0;
    end else if (w_cap) begin
      r_idx_p1  <= w_idx_p0;
      r_pred_p1 <= w_pred_p0;
    end
  end

  // ID stage: train the counter selected by the previously captured index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= INIT_STATE;
    end else if (w_upd) begin
      r_table[r_idx_p1] <= ctr_next(r_table[r_idx_p1], bus.jump_or_not);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_upd) begin
      r_branch_cnt <= sat_inc(r_branch_cnt);
      if (!w_correct) r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Randomized and directed bench for branch_history_table with a queue-based scoreboard
// and an abstract counter-array reference model.
module tb_branch_history_table;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  branch_history_table_if bus ();

  branch_history_table #(.ENTRIES(ENTRIES), .IDX_W(4), .INIT_STATE(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic        corr;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // reference model state: counters as plain integers 0..3
  int m_ctr[ENTRIES];
  int m_idx;
  bit m_pred;
  int m_bc, m_mc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    m_idx = 0; m_pred = 0; m_bc = 0; m_mc = 0;
  endtask

  // one cycle of stimulus; expectation pushed for the monitor, model advanced past the edge
  task automatic drive(input bit bif, input logic [31:0] pc, input bit bid, input bit jmp, input bit stl);
    exp_t e;
    int   idx;
    @(posedge clk); #1;
    bus.branch_IF = bif; bus.PC_IF = pc; bus.branch_ID = bid;
    bus.jump_or_not = jmp; bus.stall = stl;
    idx    = int'((pc >> 2) % ENTRIES);
    e.pred = bif ? (m_ctr[idx] >= 2) : 1'b0;
    e.corr = (!bid || stl) ? 1'b1 : (m_pred == jmp);
    e.bc   = 16'(m_bc);
    e.mc   = 16'(m_mc);
    if (bif || bid) q.push_back(e);
    if (bid && !stl) begin
      m_ctr[m_idx] = jmp ? ((m_ctr[m_idx] == 3) ? 3 : m_ctr[m_idx] + 1)
                         : ((m_ctr[m_idx] == 0) ? 0 : m_ctr[m_idx] - 1);
      if (m_bc < 65535) m_bc++;
      if (!e.corr && m_mc < 65535) m_mc++;
    end
    if (bif && !stl) begin
      m_idx  = idx;
      m_pred = e.pred;
    end
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 0);
  endtask

  task automatic pair(input logic [31:0] pc, input bit jmp);
    drive(1, pc, 0, 0, 0);
    drive(0, 32'h0, 1, jmp, 0);
  endtask

  // monitor: whenever a branch is presented, compare outputs against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (bus.branch_IF || bus.branch_ID)) begin
      if (q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("predict_jump", 32'(bus.predict_jump), 32'(e.pred));
        chk("correct",      32'(bus.correct),      32'(e.corr));
        chk("branch_cnt",   32'(bus.branch_cnt),   32'(e.bc));
        chk("miss_cnt",     32'(bus.miss_cnt),     32'(e.mc));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.branch_IF = 0; bus.PC_IF = 0; bus.branch_ID = 0;
    bus.jump_or_not = 0; bus.stall = 0;
    model_reset();

    // reset state seen while rst_n is still low
    #3;
    chk("rst_predict",    32'(bus.predict_jump), 32'd0);
    chk("rst_correct",    32'(bus.correct),      32'd1);
    chk("rst_branch_cnt", 32'(bus.branch_cnt),   32'd0);
    chk("rst_miss_cnt",   32'(bus.miss_cnt),     32'd0);
    #9 rst_n = 1'b1;

    drive(1, 32'h40, 0, 0, 0);
    idle();

    // training, saturation and hysteresis at 0x40
    pair(32'h40, 1);
    pair(32'h40, 1);
    pair(32'h40, 1);
    pair(32'h40, 1);
    pair(32'h40, 1);
    pair(32'h40, 0);
    drive(1, 32'h40, 0, 0, 0);
    idle();

    // aliasing: 0x84 shares idx 1 with 0x44, 0x48 is idx 2
    pair(32'h44, 1);
    drive(1, 32'h48, 0, 0, 0);
    drive(1, 32'h84, 0, 0, 0);
    idle();

    // stall holds everything, update lands on first unstalled cycle
    drive(1, 32'h4C, 0, 0, 0);
    drive(1, 32'h44, 1, 1, 1);
    drive(0, 32'h0,  1, 1, 1);
    drive(0, 32'h0,  1, 1, 1);
    drive(0, 32'h0,  1, 1, 0);
    drive(1, 32'h4C, 0, 0, 0);
    idle();

    // back-to-back overlapping capture/update, same-index lookup during update
    drive(1, 32'h50, 0, 0, 0);
    drive(1, 32'h50, 1, 1, 0);
    drive(1, 32'h50, 1, 1, 0);
    drive(0, 32'h0,  1, 0, 0);
    idle();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    end
    idle();

    // statistics saturation
    for (int i = 0; i < 65540; i++) drive(0, 32'h0, 1, $urandom_range(0, 1), 0);
    idle();
    chk("branch_cnt_sat", 32'(bus.branch_cnt), 32'h0000_FFFF);

    // asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1;
    chk("async_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    chk("async_miss_cnt",   32'(bus.miss_cnt),   32'd0);
    chk("async_correct",    32'(bus.correct),    32'd1);
    for (int i = 0; i < ENTRIES; i++) begin
      bus.branch_IF = 1; bus.PC_IF = 32'(i * 4);
      #1 chk("async_table", 32'(bus.predict_jump), 32'd0);
    end
    bus.branch_IF = 0; bus.PC_IF = 0;
    q.delete();
    model_reset();
    @(negedge clk); #2 rst_n = 1'b1;

    pair(32'h40, 1);
    drive(1, 32'h40, 0, 0, 0);
    idle();
    idle();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
